// File: rtl/cpu_prog_loader.sv
// Boot loader for the 4-bit CPU core.
// Accepts a byte-stream frame (header, 16 lo/hi word pairs, XOR checksum),
// writes the words into instruction memory, releases the core from reset
// once the frame checks out, and watches the core's guard flag while it runs.
module cpu_prog_loader #(
  parameter int          DEPTH = 16,
  parameter int          AW    = 4,
  parameter int          IW    = 13,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,       // active-high synchronous reset
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          core_rst,
  input  logic          core_guard,
  output logic          loaded,
  output logic          error,
  output logic [1:0]    err_code,
  output logic          fault,
  output logic [15:0]   run_cycles
);

  localparam int HW = IW - 8;   // significant bits carried by the high byte

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_WR    = 3'd3,
    S_CSUM  = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  // High byte is legal only when the bits above the word width are zero.
  function automatic logic pad_ok(input logic [7:0] b);
    return (b[7:HW] == {(8 - HW){1'b0}});
  endfunction

  state_t          state_r, state_nx_s;
  logic            xfer_s, hdr_s;
  logic [AW-1:0]   idx_r, idx_nx_s;
  logic [7:0]      xor_r, xor_nx_s;
  logic [7:0]      lo_r, lo_nx_s;
  logic            we_r, we_nx_s;
  logic [AW-1:0]   addr_r, addr_nx_s;
  logic [IW-1:0]   wdata_r, wdata_nx_s;
  logic            core_rst_r, core_rst_nx_s;
  logic            loaded_r, loaded_nx_s;
  logic            error_r, error_nx_s;
  logic [1:0]      err_code_r, err_code_nx_s;
  logic            fault_r, fault_nx_s;
  logic [15:0]     run_r, run_nx_s;

  // The only state that refuses bytes is the one-cycle memory write.
  assign in_ready = (state_r != S_WR);
  assign xfer_s   = in_valid & in_ready;
  assign hdr_s    = (in_data == HDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) state_r <= S_IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state decode; a guard failure in RUN outranks a reload header.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:  state_nx_s = (xfer_s && hdr_s) ? S_LO : S_IDLE;
      S_LO:    state_nx_s = xfer_s ? S_HI : S_LO;
      S_HI: begin
        if (xfer_s) state_nx_s = pad_ok(in_data) ? S_WR : S_ERROR;
        else        state_nx_s = S_HI;
      end
      S_WR:    state_nx_s = (idx_r == AW'(DEPTH - 1)) ? S_CSUM : S_LO;
      S_CSUM: begin
        if (xfer_s) state_nx_s = (in_data == xor_r) ? S_RUN : S_ERROR;
        else        state_nx_s = S_CSUM;
      end
      S_RUN: begin
        if (!core_guard)           state_nx_s = S_FAULT;
        else if (xfer_s && hdr_s)  state_nx_s = S_LO;
        else                       state_nx_s = S_RUN;
      end
      S_ERROR: state_nx_s = (xfer_s && hdr_s) ? S_LO : S_ERROR;
      S_FAULT: state_nx_s = (xfer_s && hdr_s) ? S_LO : S_FAULT;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    idx_nx_s      = idx_r;
    xor_nx_s      = xor_r;
    lo_nx_s       = lo_r;
    we_nx_s       = 1'b0;
    addr_nx_s     = addr_r;
    wdata_nx_s    = wdata_r;
    loaded_nx_s   = loaded_r;
    error_nx_s    = error_r;
    err_code_nx_s = err_code_r;
    fault_nx_s    = fault_r;
    run_nx_s      = run_r;
    case (state_r)
      S_IDLE, S_ERROR, S_FAULT: begin
        if (xfer_s && hdr_s) begin
          idx_nx_s      = {AW{1'b0}};
          xor_nx_s      = 8'h00;
          loaded_nx_s   = 1'b0;
          error_nx_s    = 1'b0;
          err_code_nx_s = 2'd0;
          fault_nx_s    = 1'b0;
          run_nx_s      = 16'h0000;
        end else begin
          idx_nx_s = idx_r;
        end
      end
      S_LO: begin
        if (xfer_s) begin
          lo_nx_s  = in_data;
          xor_nx_s = xor_r ^ in_data;
        end else begin
          lo_nx_s = lo_r;
        end
      end
      S_HI: begin
        if (xfer_s) begin
          xor_nx_s = xor_r ^ in_data;
          if (pad_ok(in_data)) begin
            we_nx_s    = 1'b1;
            addr_nx_s  = idx_r;
            wdata_nx_s = {in_data[HW-1:0], lo_r};
          end else begin
            error_nx_s    = 1'b1;
            err_code_nx_s = 2'd1;
          end
        end else begin
          xor_nx_s = xor_r;
        end
      end
      S_WR:    idx_nx_s = idx_r + AW'(1);
      S_CSUM: begin
        if (xfer_s) begin
          if (in_data == xor_r) begin
            loaded_nx_s = 1'b1;
          end else begin
            error_nx_s    = 1'b1;
            err_code_nx_s = 2'd2;
          end
        end else begin
          loaded_nx_s = loaded_r;
        end
      end
      S_RUN: begin
        run_nx_s = (run_r != 16'hFFFF) ? (run_r + 16'd1) : run_r;
        if (!core_guard) begin
          fault_nx_s  = 1'b1;
          loaded_nx_s = 1'b0;
        end else if (xfer_s && hdr_s) begin
          idx_nx_s    = {AW{1'b0}};
          xor_nx_s    = 8'h00;
          loaded_nx_s = 1'b0;
          run_nx_s    = 16'h0000;
        end else begin
          fault_nx_s = fault_r;
        end
      end
      default: idx_nx_s = idx_r;
    endcase
    core_rst_nx_s = (state_nx_s != S_RUN);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      idx_r      <= {AW{1'b0}};
      xor_r      <= 8'h00;
      lo_r       <= 8'h00;
      we_r       <= 1'b0;
      addr_r     <= {AW{1'b0}};
      wdata_r    <= {IW{1'b0}};
      core_rst_r <= 1'b1;
      loaded_r   <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= 2'd0;
      fault_r    <= 1'b0;
      run_r      <= 16'h0000;
    end else begin
      idx_r      <= idx_nx_s;
      xor_r      <= xor_nx_s;
      lo_r       <= lo_nx_s;
      we_r       <= we_nx_s;
      addr_r     <= addr_nx_s;
      wdata_r    <= wdata_nx_s;
      core_rst_r <= core_rst_nx_s;
      loaded_r   <= loaded_nx_s;
      error_r    <= error_nx_s;
      err_code_r <= err_code_nx_s;
      fault_r    <= fault_nx_s;
      run_r      <= run_nx_s;
    end
  end

  // A strobe already registered is withheld while reset is asserted so the
  // memory never commits a write during the reset cycle.
  assign imem_we    = we_r & ~rst_n;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign core_rst   = core_rst_r;
  assign loaded     = loaded_r;
  assign error      = error_r;
  assign err_code   = err_code_r;
  assign fault      = fault_r;
  assign run_cycles = run_r;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed self-checking bench for cpu_prog_loader.
module tb_cpu_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [12:0] imem_wdata;
  logic        core_rst;
  logic        core_guard = 1'b1;
  logic        loaded, error, fault;
  logic [1:0]  err_code;
  logic [15:0] run_cycles;

  int errors = 0;
  int checks = 0;

  logic [3:0]  wa_q[$];
  logic [12:0] wd_q[$];
  int          stall_n = 0;

  cpu_prog_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .core_guard(core_guard),
    .loaded(loaded), .error(error), .err_code(err_code), .fault(fault),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: log every write that the memory would commit.
  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      if (in_ready === 1'b0) stall_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; core_guard = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = b; n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_words();
    send_byte(8'hA5);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h00);
      send_byte(8'h02);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_rst, imem_we, imem_addr, imem_wdata, loaded, error, err_code, fault, run_cycles}
        !== {1'b1, 1'b0, 4'h0, 13'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_values: core_rst=%b we=%b addr=%h wdata=%h loaded=%b error=%b code=%0d fault=%b run=%0d required 1 0 0 0 0 0 0 0 0",
               core_rst, imem_we, imem_addr, imem_wdata, loaded, error, err_code, fault, run_cycles);
    end
    rst_n = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_good_frame(input logic garbage);
    int base, sbase, bad;
    do_reset();
    base = wa_q.size(); sbase = stall_n;
    if (garbage) begin
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      @(negedge clk); in_valid = 1'b0;
      checks++;
      if (wa_q.size() != base) begin errors++; $display("FAIL garbage_no_write: got %0d writes required 0", wa_q.size() - base); end
    end
    send_words();
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (core_rst !== 1'b1) begin errors++; $display("FAIL good_rst_before_csum: got %b required 1", core_rst); end
    send_byte(8'h00);
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (core_rst !== 1'b0) begin errors++; $display("FAIL good_core_rst_release: got %b required 0", core_rst); end
    checks++;
    if ({loaded, error, fault} !== 3'b100) begin errors++; $display("FAIL good_status: loaded/error/fault=%b required 100", {loaded, error, fault}); end
    checks++;
    if (run_cycles !== 16'd0) begin errors++; $display("FAIL good_run0: got %0d required 0", run_cycles); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (run_cycles !== 16'(k)) begin errors++; $display("FAIL good_run_count: got %0d required %0d", run_cycles, k); end
    end
    checks++;
    if (wa_q.size() - base != 16) begin errors++; $display("FAIL good_write_count: got %0d required 16", wa_q.size() - base); end
    bad = 0;
    for (int i = 0; i < 16 && base + i < wa_q.size(); i++)
      if (wa_q[base + i] !== 4'(i) || wd_q[base + i] !== 13'h0200) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL good_write_content: got %0d bad writes required 0", bad); end
    checks++;
    if (stall_n - sbase != 16) begin errors++; $display("FAIL good_stalls: got %0d required 16", stall_n - sbase); end
  endtask

  task automatic test_bad_pad();
    int base;
    do_reset();
    base = wa_q.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h22);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({error, err_code} !== 3'b101) begin errors++; $display("FAIL pad_error: error=%b code=%0d required 1 1", error, err_code); end
    checks++;
    if (core_rst !== 1'b1 || loaded !== 1'b0) begin errors++; $display("FAIL pad_core_rst: core_rst=%b loaded=%b required 1 0", core_rst, loaded); end
    checks++;
    if (wa_q.size() != base) begin errors++; $display("FAIL pad_no_write: got %0d writes required 0", wa_q.size() - base); end
  endtask

  task automatic test_bad_checksum();
    int base;
    do_reset();
    base = wa_q.size();
    send_words();
    send_byte(8'h01);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wa_q.size() - base != 16) begin errors++; $display("FAIL csum_write_count: got %0d required 16", wa_q.size() - base); end
    checks++;
    if ({error, err_code} !== 3'b110) begin errors++; $display("FAIL csum_error: error=%b code=%0d required 1 2", error, err_code); end
    checks++;
    if (core_rst !== 1'b1 || loaded !== 1'b0) begin errors++; $display("FAIL csum_core_rst: core_rst=%b loaded=%b required 1 0", core_rst, loaded); end
  endtask

  task automatic test_fault();
    do_reset();
    send_words();
    send_byte(8'h00);
    @(negedge clk); in_valid = 1'b0;           // RUN cycle 1
    repeat (4) @(negedge clk);                 // RUN cycle 5
    checks++;
    if (run_cycles !== 16'd4) begin errors++; $display("FAIL fault_pre_count: got %0d required 4", run_cycles); end
    core_guard = 1'b0;
    @(negedge clk);
    core_guard = 1'b1;
    checks++;
    if ({fault, core_rst, loaded} !== 3'b110) begin errors++; $display("FAIL fault_flags: fault/core_rst/loaded=%b required 110", {fault, core_rst, loaded}); end
    checks++;
    if (run_cycles !== 16'd5) begin errors++; $display("FAIL fault_count: got %0d required 5", run_cycles); end
    repeat (2) @(negedge clk);
    checks++;
    if (run_cycles !== 16'd5 || fault !== 1'b1) begin errors++; $display("FAIL fault_hold: run=%0d fault=%b required 5 1", run_cycles, fault); end
    send_byte(8'hA5);
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if ({fault, run_cycles, core_rst} !== {1'b0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL fault_reload: fault=%b run=%0d core_rst=%b required 0 0 1", fault, run_cycles, core_rst);
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    do_reset();
    base = wa_q.size();
    send_byte(8'hA5);
    for (int i = 0; i < 7; i++) begin
      send_byte(8'h00); send_byte(8'h02);
    end
    @(negedge clk);                            // WR cycle of word 7
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (imem_we !== 1'b0) begin errors++; $display("FAIL midrst_we_masked: got %b required 0", imem_we); end
    @(negedge clk);
    rst_n = 1'b0;
    checks++;
    if (wa_q.size() - base != 6) begin errors++; $display("FAIL midrst_write_count: got %0d required 6", wa_q.size() - base); end
    checks++;
    if ({core_rst, imem_we, imem_addr, imem_wdata, loaded, error, err_code, fault, run_cycles, in_ready}
        !== {1'b1, 1'b0, 4'h0, 13'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL midrst_values: core_rst=%b we=%b addr=%h wdata=%h loaded=%b error=%b fault=%b run=%0d required reset values",
               core_rst, imem_we, imem_addr, imem_wdata, loaded, error, fault, run_cycles);
    end
    base = wa_q.size();
    send_words();
    send_byte(8'h00);
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (wa_q.size() - base != 16 || loaded !== 1'b1 || core_rst !== 1'b0) begin
      errors++; $display("FAIL midrst_reload: writes=%0d loaded=%b core_rst=%b required 16 1 0", wa_q.size() - base, loaded, core_rst);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame(1'b0);
    test_good_frame(1'b1);
    test_bad_pad();
    test_bad_checksum();
    test_fault();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
